// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit path: the framing FSM state
//   encoding and the default byte width / sync byte used by uart_tx_arbiter
//   and anything else that talks to uart_tx.
// ----------------------------------------------------------------------------
package uart_pkg;

    // Default byte width; must match the uart_tx instance downstream.
    localparam int unsigned BITS_N_DEF = 8;

    // First byte of every frame, lets the receiver re-align after noise.
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    // Width of the payload byte counter; MAX_LEN is limited to 1..255.
    localparam int unsigned LEN_W = 8;

    // Frame sequencing: SYNC, ID, payload bytes, then XOR checksum.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ID,
        ST_PAYLOAD,
        ST_CSUM
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Returns the first asserted request at or
//   after ptr, wrapping cyclically, as a one-hot grant plus its index.
//
//   req  in   N       request vector
//   ptr  in   IDX_W   index with highest priority this round
//   gnt  out  N       one-hot grant, zero when no request is asserted
//   idx  out  IDX_W   index of the granted request (0 when none)
//   any  out  1       at least one request asserted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int unsigned N     = 3,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two passes over constant positions instead of a modular index: the
    // first pass only accepts positions >= ptr, the second (reached only if
    // the first found nothing) takes the lowest asserted position, which is
    // then necessarily below ptr. Same result as a cyclic search from ptr.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[i] && (IDX_W'(i) >= ptr)) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx byte channel between N_REQ byte-stream requesters.
//   Each packet is framed as SYNC, ID, payload..., CSUM (XOR of ID and
//   payload). Arbitration is round-robin per packet; a granted packet is
//   never interleaved with another requester's bytes.
//
//   clk        in   1             system clock
//   rst        in   1             synchronous active-high reset
//   req_valid  in   N_REQ         per-requester byte valid
//   req_data   in   N_REQ*BITS_N  requester i at [i*BITS_N +: BITS_N]
//   req_last   in   N_REQ         final payload byte of the packet
//   req_ready  out  N_REQ         byte accepted (only the granted requester)
//   tx_data    out  BITS_N        byte to uart_tx
//   tx_valid   out  1             byte offered to uart_tx
//   tx_ready   in   1             uart_tx accepts the byte
//   grant      out  N_REQ         one-hot owner, zero in IDLE
//   busy       out  1             frame in progress
//   len_err    out  1             one-cycle pulse when a frame hit MAX_LEN
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned       N_REQ     = 3,
    parameter int unsigned       BITS_N    = BITS_N_DEF,
    parameter logic [BITS_N-1:0] SYNC_BYTE = BITS_N'(SYNC_BYTE_DEF),
    parameter int unsigned       MAX_LEN   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BITS_N-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [BITS_N-1:0]       tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    len_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   g_idx_q, g_idx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [BITS_N-1:0]  csum_q, csum_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               len_err_q, len_err_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [BITS_N-1:0]  req_bytes [N_REQ];
    logic [BITS_N-1:0]  id_byte;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data[gi*BITS_N +: BITS_N];
    end

    always_comb begin
        id_byte              = '0;
        id_byte[IDX_W-1:0]   = g_idx_q;
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            g_idx_q   <= '0;
            grant_q   <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            g_idx_q   <= g_idx_d;
            grant_q   <= grant_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_idx_d   = g_idx_q;
        grant_d   = grant_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        len_err_d = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    g_idx_d = arb_idx;
                    csum_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end

            ST_SYNC: begin
                tx_valid = 1'b1;
                tx_data  = SYNC_BYTE;
                if (tx_ready) begin
                    state_d = ST_ID;
                end
            end

            ST_ID: begin
                tx_valid = 1'b1;
                tx_data  = id_byte;
                if (tx_ready) begin
                    csum_d  = id_byte;
                    state_d = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                // Straight pass-through from the owner; a stalled owner just
                // leaves tx_valid low and the FSM waits here indefinitely.
                tx_valid           = req_valid[g_idx_q];
                tx_data            = req_bytes[g_idx_q];
                req_ready[g_idx_q] = tx_ready;
                if (req_valid[g_idx_q] && tx_ready) begin
                    csum_d = csum_q ^ req_bytes[g_idx_q];
                    cnt_d  = cnt_q + 1'b1;
                    if (req_last[g_idx_q]) begin
                        state_d = ST_CSUM;
                    end else if (cnt_q == LEN_W'(MAX_LEN - 1)) begin
                        // Truncate; the rest of the packet becomes a new frame.
                        len_err_d = 1'b1;
                        state_d   = ST_CSUM;
                    end
                end
            end

            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                if (tx_ready) begin
                    ptr_d   = (g_idx_q == IDX_W'(N_REQ - 1)) ? '0 : g_idx_q + 1'b1;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign grant   = grant_q;
    assign busy    = (state_q != ST_IDLE);
    assign len_err = len_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N = 3;

    typedef struct {
        logic [7:0] d;
        logic [2:0] g;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic       last;
        int         gap;
    } pkt_byte_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  grant;
    logic        busy;
    logic        len_err;

    int errors = 0;
    int checks = 0;
    int len_err_seen = 0;
    int stall_cycles = 0;

    exp_t      sb [$];
    pkt_byte_t pend [N][$];

    uart_tx_arbiter #(
        .N_REQ     (3),
        .BITS_N    (8),
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic expect_b(input logic [7:0] d, input int g);
        exp_t e;
        e.d = d;
        e.g = 3'(1 << g);
        sb.push_back(e);
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic last, input int gap = 0);
        pkt_byte_t b;
        b.d    = d;
        b.last = last;
        b.gap  = gap;
        pend[i].push_back(b);
    endtask

    function automatic bit all_done();
        return (sb.size() == 0) && !busy &&
               (pend[0].size() == 0) && (pend[1].size() == 0) && (pend[2].size() == 0);
    endfunction

    task automatic wait_idle(input string name, input int budget, output int busy_n);
        int n = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (busy) busy_n++;
        end while (!all_done() && n < budget);
        if (!all_done()) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d bytes still expected after %0d cycles", name, sb.size(), n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Requester models: present queued bytes, pop on handshake, honour gaps.
    initial begin : driver
        logic [2:0] fire;
        pkt_byte_t  h;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (fire[i]) begin
                    if (pend[i].size() > 0) void'(pend[i].pop_front());
                end else if (pend[i].size() > 0 && pend[i][0].gap > 0) begin
                    h = pend[i][0];
                    h.gap--;
                    pend[i][0] = h;
                end
                if (pend[i].size() > 0 && pend[i][0].gap == 0) begin
                    req_valid[i]       = 1'b1;
                    req_data[i*8 +: 8] = pend[i][0].d;
                    req_last[i]        = pend[i][0].last;
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every tx handshake pops one expected byte.
    initial begin : monitor
        exp_t       e;
        logic       stall_prev;
        logic [7:0] d_prev;
        stall_prev = 1'b0;
        d_prev     = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
                continue;
            end
            if (stall_prev) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(d_prev));
            end
            if (len_err) len_err_seen++;
            if (busy && !tx_valid) stall_cycles++;
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h with grant %0b, nothing expected", tx_data, grant);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e.d));
                    chk("grant", 32'(grant), 32'(e.g));
                end
            end
            stall_prev = tx_valid && !tx_ready;
            d_prev     = tx_data;
        end
    end

    initial begin : stimulus
        int n;
        int s0;
        int le0;
        tx_ready = 1'b1;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);

        // Single frame on requester 1.
        expect_b(8'hA5, 1); expect_b(8'h01, 1); expect_b(8'h52, 1);
        expect_b(8'h3C, 1); expect_b(8'h6F, 1);
        push(1, 8'h52, 1'b0);
        push(1, 8'h3C, 1'b1);
        wait_idle("single", 100, n);
        chk("busy_cycles", 32'(n), 32'd5);

        // Round-robin: all three request at once from pointer 0.
        do_reset();
        for (int g = 0; g < 3; g++) begin
            expect_b(8'hA5, g); expect_b(8'(g), g); expect_b(8'h10, g);
            expect_b(8'h10 ^ 8'(g), g);
        end
        push(0, 8'h10, 1'b1);
        push(1, 8'h10, 1'b1);
        push(2, 8'h10, 1'b1);
        wait_idle("rr", 200, n);
        expect_b(8'hA5, 0); expect_b(8'h00, 0); expect_b(8'h10, 0); expect_b(8'h10, 0);
        push(0, 8'h10, 1'b1);
        wait_idle("rr_again", 100, n);

        // Backpressure on a 3-byte packet from requester 2.
        expect_b(8'hA5, 2); expect_b(8'h02, 2); expect_b(8'hC3, 2);
        expect_b(8'h5A, 2); expect_b(8'h99, 2); expect_b(8'h02, 2);
        tx_ready = 1'b0;
        push(2, 8'hC3, 1'b0);
        push(2, 8'h5A, 1'b0);
        push(2, 8'h99, 1'b1);
        repeat (4) begin
            repeat (434) @(posedge clk);
            #1 tx_ready = ~tx_ready;
        end
        tx_ready = 1'b1;
        wait_idle("backpressure", 200, n);

        // Requester 1 stalls 50 cycles mid-payload; requester 0 waits.
        expect_b(8'hA5, 1); expect_b(8'h01, 1); expect_b(8'h11, 1);
        expect_b(8'h22, 1); expect_b(8'h33, 1); expect_b(8'h01, 1);
        expect_b(8'hA5, 0); expect_b(8'h00, 0); expect_b(8'h7E, 0); expect_b(8'h7E, 0);
        s0 = stall_cycles;
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0, 50);
        push(1, 8'h33, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(busy && !tx_valid) && n < 100);
        if (!(busy && !tx_valid)) begin
            checks++;
            errors++;
            $display("FAIL stall_start_timeout: tx_valid stayed high for %0d busy cycles", n);
        end
        push(0, 8'h7E, 1'b1);
        repeat (25) @(negedge clk);
        chk("stall_grant", 32'(grant), 32'h2);
        chk("stall_tx_valid", 32'(tx_valid), 32'd0);
        wait_idle("stall", 300, n);
        chk("stall_cycles", 32'(stall_cycles - s0), 32'd50);

        // Truncation at MAX_LEN=4: 6-byte packet becomes 4 + 2.
        le0 = len_err_seen;
        expect_b(8'hA5, 0); expect_b(8'h00, 0); expect_b(8'h01, 0); expect_b(8'h02, 0);
        expect_b(8'h04, 0); expect_b(8'h08, 0); expect_b(8'h0F, 0);
        expect_b(8'hA5, 0); expect_b(8'h00, 0); expect_b(8'h10, 0); expect_b(8'h20, 0);
        expect_b(8'h30, 0);
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h04, 1'b0);
        push(0, 8'h08, 1'b0); push(0, 8'h10, 1'b0); push(0, 8'h20, 1'b1);
        wait_idle("trunc", 200, n);
        chk("len_err_pulses", 32'(len_err_seen - le0), 32'd1);

        // Reset after the 2nd payload byte of requester 2's frame.
        expect_b(8'hA5, 2); expect_b(8'h02, 2); expect_b(8'h44, 2); expect_b(8'h55, 2);
        push(2, 8'h44, 1'b0);
        push(2, 8'h55, 1'b0);
        push(2, 8'h66, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (sb.size() != 0 && n < 100);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL reset_setup_timeout: %0d bytes still expected", sb.size());
        end
        pend[2].delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        #1;
        expect_b(8'hA5, 0); expect_b(8'h00, 0); expect_b(8'h0A, 0); expect_b(8'h0A, 0);
        expect_b(8'hA5, 1); expect_b(8'h01, 1); expect_b(8'h0B, 1); expect_b(8'h0A, 1);
        push(0, 8'h0A, 1'b1);
        push(1, 8'h0B, 1'b1);
        wait_idle("post_reset", 200, n);

        chk("len_err_total", 32'(len_err_seen), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
